// File: rtl/heichips25_project_sched.sv
// Time-shares the tiny-project pad interface among NUM_PROJECTS user projects.
// Every switch runs drain -> reset -> run; only the running project reaches the pads.
module heichips25_project_sched #(
  parameter  int NUM_PROJECTS = 2,
  parameter  int GUARD_CYCLES = 2,
  parameter  int RESET_CYCLES = 4,
  parameter  int DEFAULT_ID   = 0,
  localparam int SEL_W        = (NUM_PROJECTS > 2) ? $clog2(NUM_PROJECTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sel_valid,
  input  logic [SEL_W-1:0]          sel_id,
  output logic                      sel_ready,
  output logic                      active,
  output logic [SEL_W-1:0]          active_id,
  output logic                      err,
  output logic [NUM_PROJECTS-1:0]   proj_ena,
  output logic [NUM_PROJECTS-1:0]   proj_rst_n,
  input  logic [8*NUM_PROJECTS-1:0] proj_uo_out,
  input  logic [8*NUM_PROJECTS-1:0] proj_uio_out,
  input  logic [8*NUM_PROJECTS-1:0] proj_uio_oe,
  output logic [7:0]                uo_out,
  output logic [7:0]                uio_out,
  output logic [7:0]                uio_oe
);

  // state    | meaning
  // ST_RESET | target project enabled but held in reset, pads idle
  // ST_RUN   | active_id project owns the pads, requests accepted
  // ST_DRAIN | every project disabled, pads idle for the guard time
  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int CNT_MAX = (GUARD_CYCLES > RESET_CYCLES) ? GUARD_CYCLES : RESET_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
  localparam logic [SEL_W-1:0] DEF_ID     = SEL_W'(DEFAULT_ID);

  logic [1:0]       state;
  logic [CNT_W-1:0] counter;
  logic [SEL_W-1:0] target;
  logic [31:0]      sel_wide;
  logic             sel_in_range;

  function automatic logic [NUM_PROJECTS-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = NUM_PROJECTS'(1) << idx;
  endfunction

  // Widened before comparing so power-of-two project counts still compile cleanly.
  assign sel_wide     = 32'(sel_id);
  assign sel_in_range = (sel_wide < 32'(NUM_PROJECTS));

  assign active    = (state == ST_RUN);
  assign sel_ready = (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RESET;
      target     <= DEF_ID;
      active_id  <= DEF_ID;
      counter    <= RESET_LOAD;
      err        <= 1'b0;
      proj_ena   <= onehot(DEF_ID);
      proj_rst_n <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          if (counter == '0) begin
            state      <= ST_RUN;
            proj_rst_n <= onehot(target);
          end else begin
            counter <= counter - 1'b1;
          end
        end
        ST_RUN: begin
          if (sel_valid) begin
            if (sel_in_range) begin
              state      <= ST_DRAIN;
              target     <= sel_id;
              counter    <= GUARD_LOAD;
              proj_ena   <= '0;
              proj_rst_n <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (counter == '0) begin
            state     <= ST_RESET;
            active_id <= target;
            counter   <= RESET_LOAD;
            proj_ena  <= onehot(target);
          end else begin
            counter <= counter - 1'b1;
          end
        end
        default: begin
          state      <= ST_RESET;
          target     <= DEF_ID;
          active_id  <= DEF_ID;
          counter    <= RESET_LOAD;
          proj_ena   <= onehot(DEF_ID);
          proj_rst_n <= '0;
        end
      endcase
    end
  end

  // Pads are released (all zero) whenever no project is running.
  always_comb begin
    uo_out  = '0;
    uio_out = '0;
    uio_oe  = '0;
    for (int i = 0; i < NUM_PROJECTS; i++) begin
      if (state == ST_RUN && active_id == SEL_W'(i)) begin
        uo_out  = proj_uo_out[8*i +: 8];
        uio_out = proj_uio_out[8*i +: 8];
        uio_oe  = proj_uio_oe[8*i +: 8];
      end
    end
  end

endmodule
